rvv_backend_dispatch_raw_scoreboard: RTL and testbench



---
 rtl/rvv_backend_dispatch_raw_scoreboard.sv | 154 +++++++++++++++
 tb/tb_rvv_backend_dispatch_raw_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_dispatch_raw_scoreboard.sv
// RAW scoreboard for RVV dispatch. Each vector register has a saturating count of
// outstanding writers, and an in-order prefix of the dispatch candidates is granted.
module rvv_backend_dispatch_raw_scoreboard #(
    parameter int NUM_VREG = 32,
    parameter int NUM_DP   = 4,
    parameter int NUM_RT   = 4,
    parameter int MAX_PEND = 7,
    parameter int V0_INDEX = 0,
    localparam int VIDX_W  = $clog2(NUM_VREG),
    localparam int CNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_DP-1:0]          dp_valid,
    input  logic [NUM_DP*VIDX_W-1:0]   dp_vs1_index,
    input  logic [NUM_DP*VIDX_W-1:0]   dp_vs2_index,
    input  logic [NUM_DP*VIDX_W-1:0]   dp_vd_index,
    input  logic [NUM_DP-1:0]          dp_vs1_valid,
    input  logic [NUM_DP-1:0]          dp_vs2_valid,
    input  logic [NUM_DP-1:0]          dp_vs3_valid,
    input  logic [NUM_DP-1:0]          dp_vm,
    input  logic [NUM_DP-1:0]          dp_vd_wr,
    output logic [NUM_DP-1:0]          dp_ready,
    input  logic [NUM_RT-1:0]          rt_valid,
    input  logic [NUM_RT*VIDX_W-1:0]   rt_w_index,
    output logic                       pend_any,
    output logic                       err_underflow
);

    localparam int SUM_W = CNT_W + 3;
    localparam logic [VIDX_W-1:0] V0_IDX = VIDX_W'(V0_INDEX);

    typedef logic [SUM_W-1:0] sum_t;

    logic [CNT_W-1:0]  cnt_q [NUM_VREG];
    logic [CNT_W-1:0]  cnt_d [NUM_VREG];
    logic              pend_any_q;
    logic              pend_any_d;
    logic              err_underflow_q;
    logic              err_underflow_d;
    logic [NUM_DP-1:0] haz;
    logic [NUM_DP-1:0] full;
    logic [NUM_DP-1:0] grant;

    // Hazard, capacity and in-order grant; chain drops to 0 at the first blocked lane.
    always_comb begin : grant_logic
        logic              chain;
        logic [VIDX_W-1:0] vs1;
        logic [VIDX_W-1:0] vs2;
        logic [VIDX_W-1:0] vd;
        logic [VIDX_W-1:0] wvd;
        logic              rd1;
        logic              rd2;
        logic              rd3;
        logic              rdm;
        sum_t              older;
        chain = 1'b1;
        haz   = '0;
        full  = '0;
        grant = '0;
        for (int i = 0; i < NUM_DP; i++) begin
            vs1 = dp_vs1_index[i*VIDX_W +: VIDX_W];
            vs2 = dp_vs2_index[i*VIDX_W +: VIDX_W];
            vd  = dp_vd_index[i*VIDX_W +: VIDX_W];
            rd1 = dp_vs1_valid[i];
            rd2 = dp_vs2_valid[i];
            rd3 = dp_vs3_valid[i];
            rdm = ~dp_vm[i];
            if ((rd1 && cnt_q[vs1] != '0) || (rd2 && cnt_q[vs2] != '0) ||
                (rd3 && cnt_q[vd] != '0)  || (rdm && cnt_q[V0_IDX] != '0)) begin
                haz[i] = 1'b1;
            end
            older = '0;
            for (int j = 0; j < NUM_DP; j++) begin
                wvd = dp_vd_index[j*VIDX_W +: VIDX_W];
                if (j < i && dp_valid[j] && dp_vd_wr[j]) begin
                    if ((rd1 && vs1 == wvd) || (rd2 && vs2 == wvd) ||
                        (rd3 && vd == wvd)  || (rdm && wvd == V0_IDX)) begin
                        haz[i] = 1'b1;
                    end
                    if (wvd == vd) begin
                        older = older + sum_t'(1);
                    end
                end
            end
            full[i]  = dp_vd_wr[i] && ((sum_t'(cnt_q[vd]) + older) >= sum_t'(MAX_PEND));
            grant[i] = chain && dp_valid[i] && !haz[i] && !full[i];
            chain    = grant[i];
        end
    end

    // Net per-register update; a negative result saturates at zero and flags underflow.
    always_comb begin : next_state
        sum_t inc;
        sum_t dec;
        sum_t sum;
        cnt_d           = cnt_q;
        err_underflow_d = err_underflow_q;
        pend_any_d      = 1'b0;
        for (int r = 0; r < NUM_VREG; r++) begin
            inc = '0;
            dec = '0;
            for (int i = 0; i < NUM_DP; i++) begin
                if (grant[i] && dp_vd_wr[i] &&
                    dp_vd_index[i*VIDX_W +: VIDX_W] == VIDX_W'(r)) begin
                    inc = inc + sum_t'(1);
                end
            end
            for (int k = 0; k < NUM_RT; k++) begin
                if (rt_valid[k] && rt_w_index[k*VIDX_W +: VIDX_W] == VIDX_W'(r)) begin
                    dec = dec + sum_t'(1);
                end
            end
            sum = sum_t'(cnt_q[r]) + inc;
            if (sum < dec) begin
                cnt_d[r]        = '0;
                err_underflow_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - dec);
            end
        end
        if (flush) begin
            for (int r = 0; r < NUM_VREG; r++) begin
                cnt_d[r] = '0;
            end
            err_underflow_d = err_underflow_q;
        end
        for (int r = 0; r < NUM_VREG; r++) begin
            if (cnt_d[r] != '0) begin
                pend_any_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_VREG; r++) begin
                cnt_q[r] <= '0;
            end
            pend_any_q      <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            pend_any_q      <= pend_any_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign dp_ready      = grant;
    assign pend_any      = pend_any_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_rvv_backend_dispatch_raw_scoreboard.sv
// Directed and random stimulus for the RAW scoreboard, checked against a per-register
// pending-count model that applies the grant rules lane by lane.
module tb_rvv_backend_dispatch_raw_scoreboard;

    localparam int NUM_VREG = 32;
    localparam int NUM_DP   = 4;
    localparam int NUM_RT   = 4;
    localparam int MAX_PEND = 7;
    localparam int V0_INDEX = 0;
    localparam int VIDX_W   = 5;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic [NUM_DP-1:0]        dp_valid;
    logic [NUM_DP*VIDX_W-1:0] dp_vs1_index;
    logic [NUM_DP*VIDX_W-1:0] dp_vs2_index;
    logic [NUM_DP*VIDX_W-1:0] dp_vd_index;
    logic [NUM_DP-1:0]        dp_vs1_valid;
    logic [NUM_DP-1:0]        dp_vs2_valid;
    logic [NUM_DP-1:0]        dp_vs3_valid;
    logic [NUM_DP-1:0]        dp_vm;
    logic [NUM_DP-1:0]        dp_vd_wr;
    logic [NUM_DP-1:0]        dp_ready;
    logic [NUM_RT-1:0]        rt_valid;
    logic [NUM_RT*VIDX_W-1:0] rt_w_index;
    logic                     pend_any;
    logic                     err_underflow;

    rvv_backend_dispatch_raw_scoreboard #(
        .NUM_VREG(NUM_VREG), .NUM_DP(NUM_DP), .NUM_RT(NUM_RT),
        .MAX_PEND(MAX_PEND), .V0_INDEX(V0_INDEX)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dp_valid(dp_valid), .dp_vs1_index(dp_vs1_index), .dp_vs2_index(dp_vs2_index),
        .dp_vd_index(dp_vd_index), .dp_vs1_valid(dp_vs1_valid), .dp_vs2_valid(dp_vs2_valid),
        .dp_vs3_valid(dp_vs3_valid), .dp_vm(dp_vm), .dp_vd_wr(dp_vd_wr), .dp_ready(dp_ready),
        .rt_valid(rt_valid), .rt_w_index(rt_w_index),
        .pend_any(pend_any), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit l_valid [NUM_DP];
    bit l_vs1v  [NUM_DP];
    bit l_vs2v  [NUM_DP];
    bit l_vs3v  [NUM_DP];
    bit l_vm    [NUM_DP];
    bit l_wr    [NUM_DP];
    int l_vs1   [NUM_DP];
    int l_vs2   [NUM_DP];
    int l_vd    [NUM_DP];
    bit r_valid [NUM_RT];
    int r_idx   [NUM_RT];
    bit flush_s;

    int cnt_m [NUM_VREG];
    bit pend_m;
    bit err_m;

    int checks = 0;
    int fails  = 0;

    task automatic clearStim();
        for (int i = 0; i < NUM_DP; i++) begin
            l_valid[i] = 0; l_vs1v[i] = 0; l_vs2v[i] = 0; l_vs3v[i] = 0;
            l_vm[i] = 1; l_wr[i] = 0; l_vs1[i] = 0; l_vs2[i] = 0; l_vd[i] = 0;
        end
        for (int k = 0; k < NUM_RT; k++) begin
            r_valid[k] = 0; r_idx[k] = 0;
        end
        flush_s = 0;
    endtask

    task automatic resetModel();
        for (int r = 0; r < NUM_VREG; r++) cnt_m[r] = 0;
        pend_m = 0;
        err_m  = 0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_DP; i++) begin
            dp_valid[i]     = l_valid[i];
            dp_vs1_valid[i] = l_vs1v[i];
            dp_vs2_valid[i] = l_vs2v[i];
            dp_vs3_valid[i] = l_vs3v[i];
            dp_vm[i]        = l_vm[i];
            dp_vd_wr[i]     = l_wr[i];
            dp_vs1_index[i*VIDX_W +: VIDX_W] = VIDX_W'(l_vs1[i]);
            dp_vs2_index[i*VIDX_W +: VIDX_W] = VIDX_W'(l_vs2[i]);
            dp_vd_index[i*VIDX_W +: VIDX_W]  = VIDX_W'(l_vd[i]);
        end
        for (int k = 0; k < NUM_RT; k++) begin
            rt_valid[k] = r_valid[k];
            rt_w_index[k*VIDX_W +: VIDX_W] = VIDX_W'(r_idx[k]);
        end
        flush = flush_s;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane reading of the grant rules over the model's pending counts.
    function automatic logic [NUM_DP-1:0] modelReady();
        logic [NUM_DP-1:0] res;
        bit blocked;
        res = '0;
        blocked = 0;
        for (int i = 0; i < NUM_DP; i++) begin
            int srcs [4];
            int ns;
            bit hz;
            int pend;
            ns = 0;
            hz = 0;
            if (l_vs1v[i]) begin srcs[ns] = l_vs1[i]; ns = ns + 1; end
            if (l_vs2v[i]) begin srcs[ns] = l_vs2[i]; ns = ns + 1; end
            if (l_vs3v[i]) begin srcs[ns] = l_vd[i];  ns = ns + 1; end
            if (!l_vm[i])  begin srcs[ns] = V0_INDEX; ns = ns + 1; end
            for (int s = 0; s < ns; s++) begin
                if (cnt_m[srcs[s]] > 0) hz = 1;
                for (int j = 0; j < i; j++)
                    if (l_valid[j] && l_wr[j] && l_vd[j] == srcs[s]) hz = 1;
            end
            pend = cnt_m[l_vd[i]];
            for (int j = 0; j < i; j++)
                if (l_valid[j] && l_wr[j] && l_vd[j] == l_vd[i]) pend = pend + 1;
            if (!blocked && l_valid[i] && !hz && !(l_wr[i] && pend >= MAX_PEND)) res[i] = 1'b1;
            else blocked = 1;
        end
        return res;
    endfunction

    task automatic modelUpdate(input logic [NUM_DP-1:0] granted);
        if (flush_s) begin
            for (int r = 0; r < NUM_VREG; r++) cnt_m[r] = 0;
        end else begin
            for (int i = 0; i < NUM_DP; i++)
                if (granted[i] && l_wr[i]) cnt_m[l_vd[i]] = cnt_m[l_vd[i]] + 1;
            for (int k = 0; k < NUM_RT; k++) begin
                if (r_valid[k]) begin
                    if (cnt_m[r_idx[k]] == 0) err_m = 1;
                    else cnt_m[r_idx[k]] = cnt_m[r_idx[k]] - 1;
                end
            end
        end
        pend_m = 0;
        for (int r = 0; r < NUM_VREG; r++) if (cnt_m[r] != 0) pend_m = 1;
    endtask

    task automatic tick(input string tag);
        logic [NUM_DP-1:0] exp;
        exp = modelReady();
        checkOutput({tag, " ready"}, 32'(dp_ready), 32'(exp));
        modelUpdate(exp);
        @(posedge clk);
        #1;
        checkOutput({tag, " pend_any"}, 32'(pend_any), 32'(pend_m));
        checkOutput({tag, " err_underflow"}, 32'(err_underflow), 32'(err_m));
    endtask

    initial begin
        rst = 1'b1;
        clearStim();
        resetModel();
        for (int i = 0; i < NUM_DP; i++) l_valid[i] = 1;
        applyStimulus();
        checkOutput("reset ready", 32'(dp_ready), 32'hf);
        checkOutput("reset pend_any", 32'(pend_any), 32'h0);
        checkOutput("reset err", 32'(err_underflow), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput("idle ready", 32'(dp_ready), 32'hf);
            tick("idle");
        end

        // write v3, read it back until the release lands
        clearStim();
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 3;
        applyStimulus();
        checkOutput("w3 grant", 32'(dp_ready), 32'h1);
        tick("w3");
        clearStim();
        l_valid[0] = 1; l_vs2v[0] = 1; l_vs2[0] = 3;
        for (int c = 1; c <= 4; c++) begin
            applyStimulus();
            checkOutput("r3 stall", 32'(dp_ready), 32'h0);
            tick("r3 stall");
        end
        r_valid[0] = 1; r_idx[0] = 3;
        applyStimulus();
        checkOutput("r3 release cycle", 32'(dp_ready), 32'h0);
        tick("r3 release");
        r_valid[0] = 0;
        applyStimulus();
        checkOutput("r3 after release", 32'(dp_ready), 32'h1);
        tick("r3 after");

        // intra-group RAW on v5
        clearStim();
        for (int i = 0; i < NUM_DP; i++) l_valid[i] = 1;
        l_wr[0] = 1; l_vd[0] = 5;
        l_vs1v[1] = 1; l_vs1[1] = 5;
        l_vs1v[2] = 1; l_vs1[2] = 11; l_vs2v[3] = 1; l_vs2[3] = 12;
        applyStimulus();
        checkOutput("intra raw", 32'(dp_ready), 32'h1);
        tick("intra raw");
        checkOutput("cnt5", 32'(dut.cnt_q[5]), 32'd1);

        // mask register dependence
        clearStim();
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 0;
        applyStimulus();
        tick("w0");
        l_wr[0] = 0;
        applyStimulus();
        checkOutput("vm1 grant", 32'(dp_ready), 32'h1);
        tick("vm1");
        l_vm[0] = 0;
        applyStimulus();
        checkOutput("vm0 stall", 32'(dp_ready), 32'h0);
        tick("vm0 stall");
        r_valid[2] = 1; r_idx[2] = 0;
        applyStimulus();
        checkOutput("vm0 release cycle", 32'(dp_ready), 32'h0);
        tick("vm0 release");
        r_valid[2] = 0;
        applyStimulus();
        checkOutput("vm0 grant", 32'(dp_ready), 32'h1);
        tick("vm0 grant");

        // fill v7 to the MAX_PEND boundary
        clearStim();
        for (int i = 0; i < NUM_DP; i++) begin l_valid[i] = 1; l_wr[i] = 1; l_vd[i] = 7; end
        applyStimulus();
        checkOutput("v7 x4", 32'(dp_ready), 32'hf);
        tick("v7 x4");
        clearStim();
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 7;
        l_valid[1] = 1; l_wr[1] = 1; l_vd[1] = 7;
        applyStimulus();
        tick("v7 x2");
        checkOutput("cnt7 six", 32'(dut.cnt_q[7]), 32'd6);
        l_valid[2] = 1; l_valid[3] = 1;
        applyStimulus();
        checkOutput("v7 full", 32'(dp_ready), 32'h1);
        tick("v7 full");
        checkOutput("cnt7 max", 32'(dut.cnt_q[7]), 32'd7);
        clearStim();
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 7;
        r_valid[0] = 1; r_idx[0] = 7; r_valid[1] = 1; r_idx[1] = 7;
        applyStimulus();
        checkOutput("v7 blocked", 32'(dp_ready), 32'h0);
        tick("v7 dual release");
        checkOutput("cnt7 five", 32'(dut.cnt_q[7]), 32'd5);

        // flush, then underflow
        clearStim();
        flush_s = 1;
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 9;
        r_valid[0] = 1; r_idx[0] = 5;
        applyStimulus();
        tick("flush");
        checkOutput("flush pend_any", 32'(pend_any), 32'h0);
        clearStim();
        for (int i = 0; i < NUM_DP; i++) l_valid[i] = 1;
        l_vs1v[0] = 1; l_vs1[0] = 5; l_vs2v[1] = 1; l_vs2[1] = 7;
        l_vs3v[2] = 1; l_vd[2] = 9; l_vm[3] = 0;
        applyStimulus();
        checkOutput("post flush reads", 32'(dp_ready), 32'hf);
        tick("post flush");
        clearStim();
        r_valid[3] = 1; r_idx[3] = 9;
        applyStimulus();
        tick("underflow");
        checkOutput("underflow flag", 32'(err_underflow), 32'h1);
        clearStim();
        applyStimulus();
        tick("sticky");
        flush_s = 1;
        applyStimulus();
        tick("flush keeps err");
        checkOutput("err after flush", 32'(err_underflow), 32'h1);

        // random traffic over a few registers
        for (int c = 0; c < 400; c++) begin
            clearStim();
            for (int i = 0; i < NUM_DP; i++) begin
                l_valid[i] = ($urandom_range(0, 9) < 8);
                l_vs1v[i] = $urandom_range(0, 1); l_vs1[i] = $urandom_range(0, 7);
                l_vs2v[i] = $urandom_range(0, 1); l_vs2[i] = $urandom_range(0, 7);
                l_vs3v[i] = ($urandom_range(0, 3) == 0);
                l_vm[i]   = ($urandom_range(0, 3) != 0);
                l_wr[i]   = ($urandom_range(0, 3) != 0);
                l_vd[i]   = $urandom_range(0, 7);
            end
            for (int k = 0; k < NUM_RT; k++) begin
                r_valid[k] = ($urandom_range(0, 9) < 3);
                r_idx[k]   = $urandom_range(0, 7);
            end
            flush_s = ($urandom_range(0, 49) == 0);
            applyStimulus();
            tick("random");
        end

        // asynchronous reset in the middle of a cycle
        clearStim();
        l_valid[0] = 1; l_wr[0] = 1; l_vd[0] = 20;
        applyStimulus();
        tick("pre reset");
        clearStim();
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        resetModel();
        checkOutput("async reset pend_any", 32'(pend_any), 32'h0);
        checkOutput("async reset err", 32'(err_underflow), 32'h0);
        checkOutput("async reset cnt20", 32'(dut.cnt_q[20]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        l_valid[0] = 1; l_vs1v[0] = 1; l_vs1[0] = 20;
        applyStimulus();
        checkOutput("after reset read", 32'(dp_ready), 32'h1);
        tick("after reset");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
